// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Supervises an ECP5 PLL from its 25 MHz reference clock. Pulses the PLL reset
// on power-up and after every lock loss, retries when lock does not arrive
// within a timeout, qualifies lock for a number of stable cycles before
// releasing the downstream system reset, and counts loss/retry events.
//
// Ports:
//   clkin     in   25 MHz reference clock (also feeds the PLL)
//   rst       in   asynchronous, active-high reset
//   locked    in   PLL LOCK, asynchronous to clkin
//   pll_rst   out  PLL RST (PLL must have PLLRST_ENA "ENABLED")
//   sys_rst   out  active-high reset for PLL-clocked logic (re-sync per domain)
//   ready     out  high only in RUN, equals ~sys_rst
//   loss_cnt  out  lock losses seen in RUN, saturating
//   retry_cnt out  lock-acquire timeouts, saturating
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int PLLRST_CYCLES  = 16,
    parameter int CNT_W          = 8
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [CNT_W-1:0] retry_cnt
);

    localparam logic [1:0] ST_PLLRST = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_STABLE = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    // One shared dwell counter, sized for the longest state.
    localparam int MAX_AB  = (STABLE_CYCLES > TIMEOUT_CYCLES) ? STABLE_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > PLLRST_CYCLES) ? MAX_AB : PLLRST_CYCLES;
    localparam int CW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

    localparam logic [CW-1:0]    PLLRST_LAST  = CW'(PLLRST_CYCLES - 1);
    localparam logic [CW-1:0]    TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]    STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    logic [1:0]       state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [CNT_W-1:0] loss_cnt_q,  loss_cnt_d;
    logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;
    logic             sync1_q,     sync1_d;
    logic             sync2_q,     sync2_d;
    logic             locked_s;

    // Two-flop synchronizer; only locked_s is used by the state machine.
    assign sync1_d  = locked;
    assign sync2_d  = sync1_q;
    assign locked_s = sync2_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        loss_cnt_d  = loss_cnt_q;
        retry_cnt_d = retry_cnt_q;

        case (state_q)
            ST_PLLRST: begin
                // Fixed-width pulse; locked_s is deliberately ignored here.
                if (cnt_q == PLLRST_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                // Lock takes priority over a coincident timeout.
                if (locked_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_PLLRST;
                    cnt_d   = '0;
                    if (retry_cnt_q != CNT_MAX) begin
                        retry_cnt_d = retry_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_STABLE: begin
                // A drop during qualification is a glitch, not a counted loss.
                if (!locked_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = ST_PLLRST;
                    if (loss_cnt_q != CNT_MAX) begin
                        loss_cnt_d = loss_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_PLLRST;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PLLRST;
            cnt_q       <= '0;
            loss_cnt_q  <= '0;
            retry_cnt_q <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
        end
    end

    // Outputs decode the state register only; no input reaches an output
    // combinationally, and an async rst shows up before the next edge.
    assign pll_rst   = (state_q == ST_PLLRST);
    assign sys_rst   = (state_q != ST_RUN);
    assign ready     = (state_q == ST_RUN);
    assign loss_cnt  = loss_cnt_q;
    assign retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Directed scenarios (startup, glitch, loss, timeout/saturation, priority,
// async reset) followed by randomized lock activity. A dwell-time reference
// model tracks the expected phase and event counts; every clock is compared.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int S   = 8;
    localparam int T   = 20;
    localparam int P   = 4;
    localparam int CW  = 2;
    localparam int SAT = (1 << CW) - 1;

    logic          clkin  = 1'b0;
    logic          rst    = 1'b1;
    logic          locked = 1'b0;
    logic          pll_rst;
    logic          sys_rst;
    logic          ready;
    logic [CW-1:0] loss_cnt;
    logic [CW-1:0] retry_cnt;

    int vectors     = 0;
    int miscompares = 0;

    pll_lock_supervisor #(
        .STABLE_CYCLES (S),
        .TIMEOUT_CYCLES(T),
        .PLLRST_CYCLES (P),
        .CNT_W         (CW)
    ) dut (
        .clkin    (clkin),
        .rst      (rst),
        .locked   (locked),
        .pll_rst  (pll_rst),
        .sys_rst  (sys_rst),
        .ready    (ready),
        .loss_cnt (loss_cnt),
        .retry_cnt(retry_cnt)
    );

    always #5 clkin = ~clkin;

    // ---------------- reference model ----------------
    // Phase plus "edges spent in phase" derived from the edge number at entry;
    // lock is seen through a two-sample history of raw samples.
    typedef enum {M_PULSE, M_WAITING, M_QUALIFY, M_RUNNING} mphase_t;

    mphase_t m_phase = M_PULSE;
    mphase_t m_nxt;
    int      m_edge  = 0;
    int      m_entry = 0;
    int      m_dwell;
    int      m_loss  = 0;
    int      m_retry = 0;
    bit      m_seen;
    bit      m_hist[$];

    always @(posedge clkin or posedge rst) begin
        if (rst) begin
            m_phase = M_PULSE;
            m_edge  = 0;
            m_entry = 0;
            m_loss  = 0;
            m_retry = 0;
            m_hist.delete();
            m_hist.push_back(1'b0);
            m_hist.push_back(1'b0);
        end else begin
            m_edge++;
            m_seen  = m_hist[0];
            m_dwell = m_edge - 1 - m_entry;
            m_nxt   = m_phase;
            case (m_phase)
                M_PULSE:   if (m_dwell == P - 1) m_nxt = M_WAITING;
                M_WAITING: begin
                    if (m_seen) m_nxt = M_QUALIFY;
                    else if (m_dwell == T - 1) begin
                        m_nxt   = M_PULSE;
                        m_retry = (m_retry < SAT) ? m_retry + 1 : SAT;
                    end
                end
                M_QUALIFY: begin
                    if (!m_seen) m_nxt = M_WAITING;
                    else if (m_dwell == S - 1) m_nxt = M_RUNNING;
                end
                M_RUNNING: begin
                    if (!m_seen) begin
                        m_nxt  = M_PULSE;
                        m_loss = (m_loss < SAT) ? m_loss + 1 : SAT;
                    end
                end
            endcase
            if (m_nxt != m_phase) begin
                m_phase = m_nxt;
                m_entry = m_edge;
            end
            m_hist.push_back(locked);
            void'(m_hist.pop_front());
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        check("model_pll_rst",   32'(pll_rst),   32'(m_phase == M_PULSE));
        check("model_sys_rst",   32'(sys_rst),   32'(m_phase != M_RUNNING));
        check("model_ready",     32'(ready),     32'(m_phase == M_RUNNING));
        check("model_loss_cnt",  32'(loss_cnt),  32'(m_loss));
        check("model_retry_cnt", 32'(retry_cnt), 32'(m_retry));
    endtask

    // Called at a negedge: drive locked, take one rising edge, check at negedge.
    task automatic step(input logic l);
        locked = l;
        @(posedge clkin);
        @(negedge clkin);
        check_model();
    endtask

    task automatic do_reset();
        locked = 1'b0;
        rst    = 1'b1;
        @(negedge clkin);
        @(negedge clkin);
        check("rst_pll_rst",   32'(pll_rst),   32'd1);
        check("rst_sys_rst",   32'(sys_rst),   32'd1);
        check("rst_ready",     32'(ready),     32'd0);
        check("rst_loss_cnt",  32'(loss_cnt),  32'd0);
        check("rst_retry_cnt", 32'(retry_cnt), 32'd0);
        rst = 1'b0;
    endtask

    // Right after rst release: count cycles pll_rst is high (incl. the one
    // before the first edge) over the next 7 edges with locked low.
    task automatic pulse_after_release(input string tag);
        int hi;
        hi = pll_rst ? 1 : 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0);
            if (pll_rst) hi++;
        end
        check(tag, 32'(hi), 32'(P));
    endtask

    // Hold locked high and count edges until sys_rst falls (bounded).
    task automatic measure_release(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            step(1'b1);
            if (!sys_rst) begin
                n = i;
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int hi;
        int prev;
        int low_run;
        int pulses;
        int len;
        logic l;

        // 1. Startup
        do_reset();
        pulse_after_release("startup_pulse_width");
        repeat (3) step(1'b0);
        measure_release(n);
        check("startup_release_latency", 32'(n), 32'(S + 3));
        check("startup_ready",     32'(ready),     32'd1);
        check("startup_loss_cnt",  32'(loss_cnt),  32'd0);
        check("startup_retry_cnt", 32'(retry_cnt), 32'd0);

        // 2. Glitch during qualification (drop at STABLE count 5)
        do_reset();
        repeat (10) step(1'b0);
        repeat (8) step(1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check("glitch_sys_rst", 32'(sys_rst), 32'd1);
        end
        check("glitch_loss_cnt", 32'(loss_cnt), 32'd0);
        measure_release(n);
        check("glitch_requalify_latency", 32'(n), 32'(S + 3));

        // 3. Loss in RUN
        step(1'b0);
        check("loss_edge1_sys_rst", 32'(sys_rst), 32'd0);
        step(1'b0);
        check("loss_edge2_sys_rst", 32'(sys_rst), 32'd0);
        step(1'b0);
        check("loss_edge3_sys_rst", 32'(sys_rst), 32'd1);
        check("loss_edge3_ready",   32'(ready),   32'd0);
        hi = pll_rst ? 1 : 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0);
            if (pll_rst) hi++;
        end
        check("loss_pulse_width", 32'(hi), 32'(P));
        check("loss_cnt_one", 32'(loss_cnt), 32'd1);
        measure_release(n);
        check("loss_relock_latency", 32'(n), 32'(S + 3));

        // Second loss to reach loss_cnt = 2, then relock
        repeat (12) step(1'b0);
        measure_release(n);
        check("loss2_relock_latency", 32'(n), 32'(S + 3));
        check("loss_cnt_two", 32'(loss_cnt), 32'd2);

        // 6. Async reset mid-cycle in RUN
        #2 rst = 1'b1;
        #1;
        check("async_sys_rst",  32'(sys_rst),  32'd1);
        check("async_pll_rst",  32'(pll_rst),  32'd1);
        check("async_loss_cnt", 32'(loss_cnt), 32'd0);
        check("async_ready",    32'(ready),    32'd0);
        @(negedge clkin);
        @(negedge clkin);
        rst = 1'b0;
        pulse_after_release("async_pulse_width");

        // 4. Timeout retries and saturation
        do_reset();
        prev    = pll_rst ? 1 : 0;
        low_run = 0;
        pulses  = 0;
        for (int i = 0; i < 5 * (T + P) + 2; i++) begin
            step(1'b0);
            if (pll_rst && prev == 0) begin
                pulses++;
                check("timeout_gap", 32'(low_run), 32'(T));
                check("timeout_retry_inc", 32'(retry_cnt), 32'((pulses < SAT) ? pulses : SAT));
            end
            if (pll_rst) low_run = 0;
            else         low_run++;
            prev = pll_rst ? 1 : 0;
        end
        check("timeout_pulse_count", 32'(pulses), 32'd5);
        check("timeout_retry_sat",   32'(retry_cnt), 32'(SAT));

        // 5. Lock arrives on the timeout edge
        do_reset();
        repeat (21) step(1'b0);
        repeat (3) step(1'b1);
        check("prio_no_pulse",       32'(pll_rst),   32'd0);
        check("prio_retry_unchanged", 32'(retry_cnt), 32'd0);
        check("prio_sys_rst",        32'(sys_rst),   32'd1);
        measure_release(n);
        check("prio_release_latency", 32'(n), 32'(S));

        // Randomized lock activity against the model
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            l   = 1'($urandom_range(0, 1));
            len = l ? int'($urandom_range(1, 25)) : int'($urandom_range(1, 12));
            repeat (len) step(l);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
